// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: ID/EX/MEM hazard inputs and pipeline control outputs.
// The slave modport is the controller side; the master modport is the pipeline side.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned RegAddrWidth = 5,
  parameter int unsigned CntWidth     = 32
) ();
  logic                    iIdValid;
  logic                    iIdRs1En;
  logic                    iIdRs2En;
  logic [RegAddrWidth-1:0] iIdRs1Addr;
  logic [RegAddrWidth-1:0] iIdRs2Addr;
  logic                    iIdIsBranch;
  logic                    iBrTrue;
  logic                    iExValid;
  logic                    iExWbEn;
  logic                    iExIsLoad;
  logic [RegAddrWidth-1:0] iExRdAddr;
  logic                    iMemReq;
  logic                    iMemAck;
  logic                    iCntClr;
  logic                    oStallIF;
  logic                    oStallID;
  logic                    oStallEX;
  logic                    oStallMEM;
  logic                    oBubbleEX;
  logic                    oBubbleWB;
  logic                    oFlushIF;
  logic                    oRedirect;
  logic [1:0]              oState;
  logic [CntWidth-1:0]     oStallCnt;
  logic [CntWidth-1:0]     oRedirCnt;

  modport slave (
    input  iIdValid, iIdRs1En, iIdRs2En, iIdRs1Addr, iIdRs2Addr, iIdIsBranch, iBrTrue,
           iExValid, iExWbEn, iExIsLoad, iExRdAddr, iMemReq, iMemAck, iCntClr,
    output oStallIF, oStallID, oStallEX, oStallMEM, oBubbleEX, oBubbleWB, oFlushIF,
           oRedirect, oState, oStallCnt, oRedirCnt
  );

  modport master (
    output iIdValid, iIdRs1En, iIdRs2En, iIdRs1Addr, iIdRs2Addr, iIdIsBranch, iBrTrue,
           iExValid, iExWbEn, iExIsLoad, iExRdAddr, iMemReq, iMemAck, iCntClr,
    input  oStallIF, oStallID, oStallEX, oStallMEM, oBubbleEX, oBubbleWB, oFlushIF,
           oRedirect, oState, oStallCnt, oRedirCnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch-dependency stalls, memory-wait freeze,
// branch redirect, plus saturating stall and redirect counters.
module pipe_hazard_ctrl #(
  parameter int unsigned RegAddrWidth = 5,
  parameter int unsigned CntWidth     = 32
) (
  input logic               iClk,
  input logic               iRst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_STALL2   = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  logic [1:0]              r_state;
  logic [1:0]              r_ret_state;
  logic [CntWidth-1:0]     r_stall_cnt;
  logic [CntWidth-1:0]     r_redir_cnt;

  logic [RegAddrWidth-1:0] w_rs1;
  logic [RegAddrWidth-1:0] w_rs2;
  logic [RegAddrWidth-1:0] w_rd;
  logic                    w_rd_live;
  logic                    w_hit;
  logic                    w_mem_busy;
  logic                    w_load_use;
  logic                    w_br_dep;

  logic [1:0]              w_next_state;
  logic [1:0]              w_next_ret;
  logic                    w_stall_if;
  logic                    w_stall_id;
  logic                    w_stall_ex;
  logic                    w_stall_mem;
  logic                    w_bubble_ex;
  logic                    w_bubble_wb;
  logic                    w_flush_if;
  logic                    w_redirect;

  assign w_rs1      = bus.iIdRs1Addr;
  assign w_rs2      = bus.iIdRs2Addr;
  assign w_rd       = bus.iExRdAddr;
  // x0 is hardwired zero, so a write to it never creates a dependency
  assign w_rd_live  = bus.iExValid & bus.iExWbEn & (w_rd != '0);
  assign w_hit      = w_rd_live & ((bus.iIdRs1En & (w_rs1 == w_rd)) |
                                   (bus.iIdRs2En & (w_rs2 == w_rd)));
  assign w_mem_busy = bus.iMemReq & ~bus.iMemAck;
  assign w_load_use = bus.iIdValid & bus.iExIsLoad & w_hit;
  assign w_br_dep   = bus.iIdValid & bus.iIdIsBranch & w_hit;

  // Next-state and control decode; outputs are zero-latency from state and inputs
  always_comb begin
    w_next_state = r_state;
    w_next_ret   = r_ret_state;
    w_stall_if   = 1'b0;
    w_stall_id   = 1'b0;
    w_stall_ex   = 1'b0;
    w_stall_mem  = 1'b0;
    w_bubble_ex  = 1'b0;
    w_bubble_wb  = 1'b0;
    w_flush_if   = 1'b0;
    w_redirect   = 1'b0;

    case (r_state)
      ST_RUN, ST_STALL2: begin
        if (w_mem_busy) begin
          {w_stall_if, w_stall_id, w_stall_ex, w_stall_mem} = 4'hF;
          w_bubble_wb  = 1'b1;
          w_next_ret   = r_state;
          w_next_state = ST_MEM_WAIT;
        end else if (r_state == ST_STALL2) begin
          w_stall_if   = 1'b1;
          w_stall_id   = 1'b1;
          w_bubble_ex  = 1'b1;
          w_next_state = ST_RUN;
        end else if (w_load_use | w_br_dep) begin
          w_stall_if   = 1'b1;
          w_stall_id   = 1'b1;
          w_bubble_ex  = 1'b1;
          // a branch waiting on a load needs the loaded value one cycle later still
          w_next_state = (w_br_dep & bus.iExIsLoad) ? ST_STALL2 : ST_RUN;
        end else if (bus.iIdValid & bus.iBrTrue) begin
          w_redirect   = 1'b1;
          w_flush_if   = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        {w_stall_if, w_stall_id, w_stall_ex, w_stall_mem} = 4'hF;
        w_bubble_wb = 1'b1;
        if (bus.iMemAck) begin
          w_next_state = r_ret_state;
        end
      end
      default: begin
        w_next_state = ST_RUN;
      end
    endcase

    if (iRst) begin
      w_stall_if  = 1'b0;
      w_stall_id  = 1'b0;
      w_stall_ex  = 1'b0;
      w_stall_mem = 1'b0;
      w_bubble_ex = 1'b0;
      w_bubble_wb = 1'b0;
      w_flush_if  = 1'b0;
      w_redirect  = 1'b0;
    end
  end

  // State and return-state registers
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state     <= ST_RUN;
      r_ret_state <= ST_RUN;
    end else begin
      r_state     <= w_next_state;
      r_ret_state <= w_next_ret;
    end
  end

  // Saturating performance counters; clear wins over increment
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_stall_cnt <= '0;
      r_redir_cnt <= '0;
    end else if (bus.iCntClr) begin
      r_stall_cnt <= '0;
      r_redir_cnt <= '0;
    end else begin
      if (w_stall_id && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CntWidth'(1);
      end
      if (w_redirect && (r_redir_cnt != '1)) begin
        r_redir_cnt <= r_redir_cnt + CntWidth'(1);
      end
    end
  end

  assign bus.oStallIF  = w_stall_if;
  assign bus.oStallID  = w_stall_id;
  assign bus.oStallEX  = w_stall_ex;
  assign bus.oStallMEM = w_stall_mem;
  assign bus.oBubbleEX = w_bubble_ex;
  assign bus.oBubbleWB = w_bubble_wb;
  assign bus.oFlushIF  = w_flush_if;
  assign bus.oRedirect = w_redirect;
  assign bus.oState    = r_state;
  assign bus.oStallCnt = r_stall_cnt;
  assign bus.oRedirCnt = r_redir_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios then random traffic,
// expected responses from a behavioural model queued per cycle and checked by a monitor.
module tb_pipe_hazard_ctrl;

  localparam int unsigned AW      = 5;
  localparam int unsigned CW      = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;
  localparam int          RUN     = 0;
  localparam int          STALL2  = 1;
  localparam int          MWAIT   = 2;

  typedef struct {
    bit          rst;
    bit          id_valid;
    bit          rs1_en;
    bit          rs2_en;
    bit [AW-1:0] rs1;
    bit [AW-1:0] rs2;
    bit          is_branch;
    bit          br_true;
    bit          ex_valid;
    bit          ex_wb;
    bit          ex_load;
    bit [AW-1:0] ex_rd;
    bit          mem_req;
    bit          mem_ack;
    bit          cnt_clr;
  } stim_t;

  typedef struct {
    bit [3:0]    stalls;   // {IF, ID, EX, MEM}
    bit          bubble_ex;
    bit          bubble_wb;
    bit          flush_if;
    bit          redirect;
    bit [1:0]    state;
    bit [CW-1:0] stall_cnt;
    bit [CW-1:0] redir_cnt;
  } exp_t;

  logic iClk;
  logic iRst;

  pipe_hazard_ctrl_if #(.RegAddrWidth(AW), .CntWidth(CW)) bus ();

  pipe_hazard_ctrl #(.RegAddrWidth(AW), .CntWidth(CW)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  exp_t exp_q[$];
  bit   done = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: pipeline occupancy kept as plain integers
  int m_state = RUN;
  int m_ret   = RUN;
  int m_sc    = 0;
  int m_rc    = 0;

  function automatic exp_t model_step(input stim_t s);
    exp_t e;
    bit   busy, dep, lu, bd;
    int   nxt, nret;
    if (s.rst) begin
      m_state = RUN; m_ret = RUN; m_sc = 0; m_rc = 0;
    end
    e = '{default: '0};
    e.state     = 2'(m_state);
    e.stall_cnt = CW'(m_sc);
    e.redir_cnt = CW'(m_rc);
    busy = s.mem_req && !s.mem_ack;
    dep  = s.ex_valid && s.ex_wb && (s.ex_rd != 0) &&
           ((s.rs1_en && s.rs1 == s.ex_rd) || (s.rs2_en && s.rs2 == s.ex_rd));
    lu   = s.id_valid && s.ex_load && dep;
    bd   = s.id_valid && s.is_branch && dep;
    nxt  = m_state;
    nret = m_ret;
    if (!s.rst) begin
      if (m_state == MWAIT) begin
        e.stalls = 4'hF; e.bubble_wb = 1;
        if (s.mem_ack) nxt = m_ret;
      end else if (busy) begin
        e.stalls = 4'hF; e.bubble_wb = 1;
        nret = m_state; nxt = MWAIT;
      end else if (m_state == STALL2) begin
        e.stalls = 4'b1100; e.bubble_ex = 1; nxt = RUN;
      end else if (lu || bd) begin
        e.stalls = 4'b1100; e.bubble_ex = 1;
        nxt = (bd && s.ex_load) ? STALL2 : RUN;
      end else if (s.id_valid && s.br_true) begin
        e.redirect = 1; e.flush_if = 1;
      end
      if (s.cnt_clr) begin
        m_sc = 0; m_rc = 0;
      end else begin
        if (e.stalls[2] && m_sc < CNT_MAX) m_sc++;
        if (e.redirect && m_rc < CNT_MAX) m_rc++;
      end
      m_state = nxt;
      m_ret   = nret;
    end
    return e;
  endfunction

  // One cycle of stimulus: drive after the edge, queue the expected response
  task automatic drive(input stim_t s);
    @(posedge iClk);
    #1;
    iRst            = s.rst;
    bus.iIdValid    = s.id_valid;
    bus.iIdRs1En    = s.rs1_en;
    bus.iIdRs2En    = s.rs2_en;
    bus.iIdRs1Addr  = s.rs1;
    bus.iIdRs2Addr  = s.rs2;
    bus.iIdIsBranch = s.is_branch;
    bus.iBrTrue     = s.br_true;
    bus.iExValid    = s.ex_valid;
    bus.iExWbEn     = s.ex_wb;
    bus.iExIsLoad   = s.ex_load;
    bus.iExRdAddr   = s.ex_rd;
    bus.iMemReq     = s.mem_req;
    bus.iMemAck     = s.mem_ack;
    bus.iCntClr     = s.cnt_clr;
    exp_q.push_back(model_step(s));
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t ex_write(input bit [AW-1:0] rd, input bit load);
    stim_t s;
    s = idle();
    s.ex_valid = 1; s.ex_wb = 1; s.ex_load = load; s.ex_rd = rd;
    return s;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp, input int cyc);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every negedge the DUT presents one response for the oldest queued stimulus
  initial begin
    exp_t e;
    int   cyc = 0;
    forever begin
      @(negedge iClk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("stalls",    32'({bus.oStallIF, bus.oStallID, bus.oStallEX, bus.oStallMEM}), 32'(e.stalls), cyc);
        cmp("bubble",    32'({bus.oBubbleEX, bus.oBubbleWB}), 32'({e.bubble_ex, e.bubble_wb}), cyc);
        cmp("redirect",  32'({bus.oRedirect, bus.oFlushIF}), 32'({e.redirect, e.flush_if}), cyc);
        cmp("state",     32'(bus.oState), 32'(e.state), cyc);
        cmp("stall_cnt", 32'(bus.oStallCnt), 32'(e.stall_cnt), cyc);
        cmp("redir_cnt", 32'(bus.oRedirCnt), 32'(e.redir_cnt), cyc);
        cmp("redir_vs_stall", 32'(bus.oRedirect & bus.oStallID), 32'(0), cyc);
        cyc++;
      end else if (done) begin
        break;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  // Stimulus: directed scenarios followed by random traffic
  initial begin
    stim_t s;
    iRst = 1'b1;
    s = idle(); s.rst = 1;
    drive(s); drive(s);
    drive(idle());

    // Load x5 in EX, add reads rs2=x5: one stall
    s = ex_write(5, 1); s.id_valid = 1; s.rs1_en = 1; s.rs1 = 1; s.rs2_en = 1; s.rs2 = 5;
    drive(s);
    drive(idle()); drive(idle());

    // Load x7, beq on rs1=x7: two stalls, no redirect
    s = ex_write(7, 1); s.id_valid = 1; s.is_branch = 1; s.br_true = 1; s.rs1_en = 1; s.rs1 = 7;
    drive(s);
    s.ex_valid = 0;
    drive(s);
    s = idle(); s.id_valid = 1; s.is_branch = 1; s.br_true = 1; s.rs1_en = 1; s.rs1 = 7;
    drive(s);
    drive(idle());
    // ALU writes x7 instead: one stall
    s = ex_write(7, 0); s.id_valid = 1; s.is_branch = 1; s.rs1_en = 1; s.rs1 = 7;
    drive(s);
    drive(idle());

    // x0 never hazards
    s = ex_write(0, 1); s.id_valid = 1; s.rs1_en = 1; s.rs2_en = 1;
    drive(s);

    // STALL2 interrupted by a three-cycle memory wait
    s = ex_write(7, 1); s.id_valid = 1; s.is_branch = 1; s.rs2_en = 1; s.rs2 = 7;
    drive(s);
    s = idle(); s.mem_req = 1;
    drive(s); drive(s); drive(s);
    s.mem_ack = 1;
    drive(s);
    drive(idle()); drive(idle());

    // Taken branch alone, then with memory busy
    s = idle(); s.id_valid = 1; s.br_true = 1;
    drive(s);
    s.mem_req = 1;
    drive(s);
    s = idle(); s.mem_req = 1; s.mem_ack = 1;
    drive(s);
    drive(idle());

    // Counter saturation, clear, then reset mid-wait
    s = idle(); s.cnt_clr = 1;
    drive(s);
    s = idle(); s.mem_req = 1;
    for (int i = 0; i < CNT_MAX - 1 + 3; i++) drive(s);
    s = idle(); s.cnt_clr = 1; s.mem_req = 1;
    drive(s);
    s.cnt_clr = 0; s.mem_req = 0;
    drive(s);
    s = idle(); s.rst = 1;
    drive(s);
    drive(idle()); drive(idle());

    // Random traffic on a small register window to provoke hits
    for (int i = 0; i < 2000; i++) begin
      s = idle();
      s.rst       = ($urandom_range(0, 99) == 0);
      s.id_valid  = ($urandom_range(0, 3) != 0);
      s.rs1_en    = $urandom_range(0, 1) != 0;
      s.rs2_en    = $urandom_range(0, 1) != 0;
      s.rs1       = AW'($urandom_range(0, 3));
      s.rs2       = AW'($urandom_range(0, 3));
      s.is_branch = ($urandom_range(0, 2) == 0);
      s.br_true   = ($urandom_range(0, 2) == 0);
      s.ex_valid  = ($urandom_range(0, 3) != 0);
      s.ex_wb     = ($urandom_range(0, 3) != 0);
      s.ex_load   = $urandom_range(0, 1) != 0;
      s.ex_rd     = AW'($urandom_range(0, 3));
      s.mem_req   = ($urandom_range(0, 4) == 0);
      s.mem_ack   = $urandom_range(0, 1) != 0;
      s.cnt_clr   = ($urandom_range(0, 59) == 0);
      drive(s);
    end
    drive(idle());
    done = 1'b1;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter RegAddrWidth, default 5, register address width.
REQ-002 SHALL have parameter CntWidth, default 32, performance counter width.
REQ-003 SHALL have a single clock and an asynchronous, active-high reset, with ports as follows.
- iClk  in  1  clock, all state updates on rising edge.
- iRst  in  1  asynchronous active-high reset.
- iIdValid  in  1  ID holds a valid instruction.
- iIdRs1En, iIdRs2En  in  1 each  ID instruction reads rs1 / rs2.
- iIdRs1Addr, iIdRs2Addr  in  RegAddrWidth each  ID source addresses.
- iIdIsBranch  in  1  ID instruction is a conditional branch (resolved in ID).
- iBrTrue  in  1  ID branch/jump taken.
- iExValid, iExWbEn, iExIsLoad  in  1 each  EX instruction valid / writes rd / is load.
- iExRdAddr  in  RegAddrWidth  EX destination.
- iMemReq, iMemAck  in  1 each  MEM-stage data-memory request / acknowledge.
- iCntClr  in  1  synchronous counter clear.
- oStallIF, oStallID, oStallEX, oStallMEM  out  1 each  hold stage register.
- oBubbleEX, oBubbleWB  out  1 each  load zeroed control (valid=0) into EX / WB.
- oFlushIF  out  1  clear IF/ID register.
- oRedirect  out  1  PC takes branch target.
- oState  out  2  FSM state (RUN=0, STALL2=1, MEM_WAIT=2).
- oStallCnt  out  CntWidth  cycles with oStallID=1.
- oRedirCnt  out  CntWidth  redirect count.

Function
REQ-004 mem_busy = iMemReq & ~iMemAck.
REQ-005 rs_hit(a) = (a == iExRdAddr) & (iExRdAddr != 0) & iExValid & iExWbEn; a hazard is never raised against x0.
REQ-006 load_use = iIdValid & iExIsLoad & ((iIdRs1En & rs_hit(rs1)) | (iIdRs2En & rs_hit(rs2))).
REQ-007 br_dep = iIdValid & iIdIsBranch & ((iIdRs1En & rs_hit(rs1)) | (iIdRs2En & rs_hit(rs2))).
REQ-008 Control outputs SHALL be combinational from state and inputs (zero latency); state and counters SHALL be registered.
REQ-009 RUN, priority 1, mem_busy: all four stalls=1, oBubbleWB=1, oRedirect=oFlushIF=0; save return state RUN; next MEM_WAIT.
REQ-010 RUN, priority 2, load_use|br_dep: oStallIF=oStallID=1, oBubbleEX=1, oRedirect=oFlushIF=0; next STALL2 if br_dep&iExIsLoad, else RUN.
REQ-011 RUN, priority 3, iIdValid&iBrTrue: oRedirect=1, oFlushIF=1, no stalls; next RUN.
REQ-012 RUN, otherwise: all outputs 0.
REQ-013 STALL2: oStallIF=oStallID=1, oBubbleEX=1, oRedirect=0; next RUN; if mem_busy, apply REQ-009 outputs instead, save return state STALL2, next MEM_WAIT.
REQ-014 MEM_WAIT: all four stalls=1, oBubbleWB=1; when iMemAck=1 in the same cycle, outputs still stall this cycle and next state = saved return state.
REQ-015 oRedirect SHALL never assert in a cycle where oStallID=1.
REQ-016 oStallCnt SHALL increment by 1 each cycle oStallID=1; oRedirCnt by 1 each cycle oRedirect=1; both saturate at all-ones (no wrap).
REQ-017 iCntClr SHALL zero both counters next edge, overriding a same-cycle increment.
REQ-018 Illegal state encoding 3 SHALL transition to RUN with all outputs 0.

Reset
REQ-019 iRst=1 SHALL immediately (asynchronously) force state RUN, saved return RUN, and both counters 0.
REQ-020 While iRst=1 all stall/bubble/flush/redirect outputs SHALL be 0 regardless of inputs.
REQ-021 Reset asserted mid-MEM_WAIT or mid-STALL2 SHALL abandon the sequence; first cycle after release is RUN.

Verification
REQ-022 Load x5 in EX, ID add reads rs2=x5 -> one cycle oStallIF=oStallID=oBubbleEX=1, then RUN with no stall; oStallCnt=1.
REQ-023 Load x7 in EX, ID beq reads rs1=x7 -> two stall cycles (RUN->STALL2->RUN), oRedirect=0 both cycles; ALU writing x7 instead -> one stall cycle.
REQ-024 EX writes x0, ID reads x0 -> no stall.
REQ-025 In STALL2, iMemReq=1 with iMemAck low 3 cycles -> MEM_WAIT 3 cycles with all stalls and oBubbleWB=1, then STALL2, then RUN.
REQ-026 Taken branch with no hazard -> oRedirect=oFlushIF=1 for one cycle, oRedirCnt +1; same with mem_busy -> no redirect, MEM_WAIT.
REQ-027 Preload oStallCnt to all-ones minus 1 via continuous stall, stall 3 more cycles -> saturates at all-ones; iCntClr -> 0; iRst during MEM_WAIT -> oState=0 immediately.
